// File: rtl/period_meter_if.sv
// Signal bundle between a square-wave source and the period meter.
// The source side uses master; the meter uses slave.
interface period_meter_if #(
  parameter int N = 11
);
  logic         sig_in;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         valid;
  logic         stable;
  logic         timeout;

  modport master (
    output sig_in,
    input  period, high_time, valid, stable, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, valid, stable, timeout
  );
endinterface

// File: rtl/period_meter.sv
// Measures rising-to-rising period and rising-to-falling high time of sig_in
// in clk cycles, with stability and saturation-timeout status.
module period_meter #(
  parameter int N = 11
) (
  input  logic           clk,
  input  logic           rst,
  period_meter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

  state_t       r_state;
  logic         r_s1, r_s2, r_s3;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_hcap;
  logic         r_fseen;
  logic         r_have_prev;
  logic [N-1:0] r_period;
  logic [N-1:0] r_high;
  logic         r_valid;
  logic         r_stable;
  logic         r_timeout;

  logic w_rise;
  logic w_fall;
  logic w_sat;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_sat  = (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_hcap      <= '0;
      r_fseen     <= 1'b0;
      r_have_prev <= 1'b0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_stable    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s1    <= bus.sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cnt   <= N'(1);
            r_fseen <= 1'b0;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            // A rise with no falling edge since the reference is a glitch:
            // restart the count without reporting anything.
            if (r_fseen) begin
              r_period    <= r_cnt;
              r_high      <= r_hcap;
              r_valid     <= 1'b1;
              r_stable    <= r_have_prev && (r_cnt == r_period);
              r_timeout   <= 1'b0;
              r_have_prev <= 1'b1;
            end
            r_cnt   <= N'(1);
            r_fseen <= 1'b0;
          end else if (w_sat) begin
            r_timeout   <= 1'b1;
            r_stable    <= 1'b0;
            r_have_prev <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + N'(1);
            if (w_fall) begin
              r_hcap  <= r_cnt;
              r_fseen <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high;
  assign bus.valid     = r_valid;
  assign bus.stable    = r_stable;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: N=11 and N=4 instances share one
// stimulus stream; a sample-level reference model predicts every report.
module tb_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;

  always #5 clk = ~clk;

  period_meter_if #(.N(11)) if11 ();
  period_meter_if #(.N(4))  if4 ();

  assign if11.sig_in = sig_in;
  assign if4.sig_in  = sig_in;

  period_meter #(.N(11)) u_dut11 (.clk(clk), .rst(rst), .bus(if11));
  period_meter #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    bit is_to;
    int cyc;
    int per;
    int hi;
    bit stb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int edge_cnt  = 0;
  int checks    = 0;
  int errors    = 0;
  int zero_req  = 0;
  int zero_done = 0;
  bit done      = 1'b0;

  // Reference model state, index 0 = N=11, index 1 = N=4
  bit mprev[2];
  bit mmeas[2];
  bit mfs[2];
  bit mhavep[2];
  int mref[2];
  int mfall[2];
  int mlastp[2];
  int mlasth[2];
  bit ptmo[2];

  function automatic void push(int i, exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mprev[i]  = 1'b0;
      mmeas[i]  = 1'b0;
      mfs[i]    = 1'b0;
      mhavep[i] = 1'b0;
      mref[i]   = 0;
      mfall[i]  = 0;
      mlastp[i] = 0;
      mlasth[i] = 0;
    end
  endfunction

  // Works on sample edges: an input change sampled at edge k shows on the
  // outputs after edge k+2.
  function automatic void model_step(int i, bit v, int k);
    int   maxc = (i == 0) ? 2047 : 15;
    bit   rise = v && !mprev[i];
    bit   fall = !v && mprev[i];
    exp_t e;
    mprev[i] = v;
    if (!mmeas[i]) begin
      if (rise) begin
        mmeas[i] = 1'b1;
        mref[i]  = k;
        mfs[i]   = 1'b0;
      end
    end else if (rise) begin
      if (mfs[i]) begin
        e.is_to   = 1'b0;
        e.cyc     = k + 2;
        e.per     = k - mref[i];
        e.hi      = mfall[i] - mref[i];
        e.stb     = mhavep[i] && (e.per == mlastp[i]);
        push(i, e);
        mlastp[i] = e.per;
        mlasth[i] = e.hi;
        mhavep[i] = 1'b1;
      end
      mref[i] = k;
      mfs[i]  = 1'b0;
    end else if (k - mref[i] == maxc) begin
      e.is_to   = 1'b1;
      e.cyc     = k + 2;
      e.per     = mlastp[i];
      e.hi      = mlasth[i];
      e.stb     = 1'b0;
      push(i, e);
      mmeas[i]  = 1'b0;
      mhavep[i] = 1'b0;
    end else if (fall) begin
      mfs[i]   = 1'b1;
      mfall[i] = k;
    end
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i, sig_in, edge_cnt);
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  task automatic mon(input int i, input bit v, input bit tmo, input bit stb,
                     input int per, input int hi);
    exp_t e;
    bit   trig = v || (tmo && !ptmo[i]);
    bit   empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    ptmo[i] = tmo;
    if (trig) begin
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL i%0d_unexpected: got valid=%0b timeout=%0b at cycle %0d, expected no report",
                 i, v, tmo, edge_cnt);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("i%0d_valid", i), int'(v), int'(!e.is_to));
        check($sformatf("i%0d_timeout", i), int'(tmo), int'(e.is_to));
        check($sformatf("i%0d_cycle", i), edge_cnt, e.cyc);
        check($sformatf("i%0d_period", i), per, e.per);
        check($sformatf("i%0d_high_time", i), hi, e.hi);
        check($sformatf("i%0d_stable", i), int'(stb), int'(e.stb));
      end
    end
  endtask

  always @(negedge clk) begin
    if (zero_req != zero_done) begin
      zero_done = zero_req;
      check("i0_reset_state",
            int'({if11.period, if11.high_time, if11.valid, if11.stable, if11.timeout}), 0);
      check("i1_reset_state",
            int'({if4.period, if4.high_time, if4.valid, if4.stable, if4.timeout}), 0);
    end
    mon(0, if11.valid, if11.timeout, if11.stable, int'(if11.period), int'(if11.high_time));
    mon(1, if4.valid, if4.timeout, if4.stable, int'(if4.period), int'(if4.high_time));
    if (done) begin
      check("i0_queue_drained", q0.size(), 0);
      check("i1_queue_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      sig_in = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int reps);
    repeat (reps) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 zero_req++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int h, l, r;
    repeat (3) @(negedge clk);
    pulse_reset();
    drive(1'b0, 3);

    wave(5, 5, 4);
    wave(4, 3, 5);
    wave(5, 5, 3);
    wave(3, 3, 3);
    wave(1, 1, 6);

    // reset in the middle of a measurement, input held low around it
    wave(3, 5, 2);
    drive(1'b1, 2);
    drive(1'b0, 4);
    pulse_reset();
    drive(1'b0, 2);
    wave(4, 4, 3);

    // stuck low after one rise: N=4 instance saturates
    wave(2, 2, 3);
    drive(1'b1, 1);
    drive(1'b0, 25);
    wave(2, 3, 3);

    for (int s = 0; s < 25; s++) begin
      h = $urandom_range(1, 9);
      l = $urandom_range(1, 9);
      r = $urandom_range(1, 3);
      wave(h, l, r);
      if (s % 8 == 7) drive(1'b0, $urandom_range(12, 20));
    end

    drive(1'b0, 20);
    done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
